// File: rtl/fht_adc_loader.sv
// ADC front-end for fht_top: converts signed samples to FHT fixed point, fills the
// four banks row by row, fires a one-cycle start and holds off until the FHT is done.
module fht_adc_loader #(
   parameter int ADC_WIDTH = 14,
   parameter int D_BIT     = 22,
   parameter int A_BIT     = 8
) (
   input  logic                 iCLK,
   input  logic                 iRESET,
   input  logic [ADC_WIDTH-1:0] iADC_DATA,
   input  logic                 iADC_VALID,
   input  logic                 iBIT_REV,
   input  logic                 iFHT_RDY,
   output logic [3:0]           oWE,
   output logic [D_BIT-1:0]     oDATA,
   output logic [A_BIT-1:0]     oADDR_WR,
   output logic                 oSTART,
   output logic                 oBUSY,
   output logic                 oDROP,
   output logic [15:0]          oDROP_CNT
);

   localparam int CW = A_BIT + 2;

   typedef enum logic [1:0] {LOAD, START, WAIT_ACK, WAIT_DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               rev_q, rev_d;
   logic [3:0]         we_q, we_d;
   logic [D_BIT-1:0]   data_q, data_d;
   logic [A_BIT-1:0]   addr_q, addr_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;
   logic               drop_q, drop_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;

   logic [A_BIT-1:0]   row;
   logic [D_BIT-1:0]   fixp;
   logic               rev_now;

   function automatic logic [A_BIT-1:0] bitrev(input logic [A_BIT-1:0] r);
      logic [A_BIT-1:0] res;
      for (int i = 0; i < A_BIT; i++) res[i] = r[A_BIT-1-i];
      return res;
   endfunction

   assign row = cnt_q[CW-1:2];

   // Sample sits in the top bits; the fractional bits below it are zero.
   always_comb begin
      fixp = '0;
      fixp[D_BIT-1 -: ADC_WIDTH] = iADC_DATA;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rev_d      = rev_q;
      we_d       = '0;
      data_d     = data_q;
      addr_d     = addr_q;
      start_d    = 1'b0;
      drop_d     = 1'b0;
      drop_cnt_d = drop_cnt_q;
      rev_now    = rev_q;

      case (state_q)
         LOAD: begin
            if (iADC_VALID) begin
               // Address order is frozen by the first sample of the frame.
               rev_now = (cnt_q == '0) ? iBIT_REV : rev_q;
               rev_d   = rev_now;
               we_d    = 4'(4'b0001 << cnt_q[1:0]);
               data_d  = fixp;
               addr_d  = rev_now ? bitrev(row) : row;
               cnt_d   = cnt_q + CW'(1);
               if (&cnt_q) begin
                  state_d = START;
                  start_d = 1'b1;
               end
            end
         end
         START:     state_d = WAIT_ACK;
         WAIT_ACK:  if (!iFHT_RDY) state_d = WAIT_DONE;
         WAIT_DONE: if (iFHT_RDY)  state_d = LOAD;
         default:   state_d = LOAD;
      endcase

      if (state_q != LOAD && iADC_VALID) begin
         drop_d = 1'b1;
         if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end

      busy_d = (state_d != LOAD);
   end

   always_ff @(posedge iCLK) begin
      if (!iRESET) begin
         state_q    <= LOAD;
         cnt_q      <= '0;
         rev_q      <= 1'b0;
         we_q       <= '0;
         data_q     <= '0;
         addr_q     <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rev_q      <= rev_d;
         we_q       <= we_d;
         data_q     <= data_d;
         addr_q     <= addr_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
         drop_q     <= drop_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign oWE       = we_q;
   assign oDATA     = data_q;
   assign oADDR_WR  = addr_q;
   assign oSTART    = start_q;
   assign oBUSY     = busy_q;
   assign oDROP     = drop_q;
   assign oDROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_fht_adc_loader.sv
// Directed bench for fht_adc_loader with A_BIT=2 (16-sample frames), D_BIT=22, ADC_WIDTH=14.
module tb_fht_adc_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [13:0] adc;
   logic        vld;
   logic        brev;
   logic        rdy;
   logic [3:0]  we;
   logic [21:0] data;
   logic [1:0]  addr;
   logic        start, busy, drop;
   logic [15:0] drop_cnt;

   int tests = 0;
   int fails = 0;
   int start_cnt = 0;

   fht_adc_loader #(.ADC_WIDTH(14), .D_BIT(22), .A_BIT(2)) dut (
      .iCLK(clk), .iRESET(rst_n), .iADC_DATA(adc), .iADC_VALID(vld),
      .iBIT_REV(brev), .iFHT_RDY(rdy), .oWE(we), .oDATA(data),
      .oADDR_WR(addr), .oSTART(start), .oBUSY(busy), .oDROP(drop),
      .oDROP_CNT(drop_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (start === 1'b1) start_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [13:0] v;
      logic [1:0]  rev_tab [4];
      rev_tab[0] = 2'd0; rev_tab[1] = 2'd2; rev_tab[2] = 2'd1; rev_tab[3] = 2'd3;

      rst_n = 1'b0; vld = 1'b0; adc = '0; brev = 1'b0; rdy = 1'b1;
      tick(); tick();
      chk("rst_we", 32'(we), 0);
      chk("rst_data", 32'(data), 0);
      chk("rst_addr", 32'(addr), 0);
      chk("rst_start", 32'(start), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_dropcnt", 32'(drop_cnt), 0);
      rst_n = 1'b1;

      // Frame 1: ramp 0..15, natural order, continuous full rate
      for (int n = 0; n < 16; n++) begin
         vld = 1'b1; adc = 14'(n);
         tick();
         chk("f1_we", 32'(we), 32'(1 << (n % 4)));
         chk("f1_addr", 32'(addr), 32'(n / 4));
         chk("f1_data", 32'(data), 32'(n * 256));
         chk("f1_start", 32'(start), (n == 15) ? 1 : 0);
         if (n == 5) begin
            chk("s5_we", 32'(we), 32'h2);
            chk("s5_addr", 32'(addr), 1);
            chk("s5_data", 32'(data), 32'h500);
         end
      end
      chk("f1_busy_at_start", 32'(busy), 1);
      vld = 1'b0;

      // fht_top model: RDY drops 3 cycles after START
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hs_busy_ack", 32'(busy), 1);
         chk("hs_nostart", 32'(start), 0);
      end
      rdy = 1'b0;
      tick();
      chk("hs_busy_drop", 32'(busy), 1);

      // Drop path: three samples while WAIT_DONE
      for (int i = 0; i < 3; i++) begin
         vld = 1'b1; adc = 14'h1234;
         tick();
         chk("drop_pulse", 32'(drop), 1);
         chk("drop_nowe", 32'(we), 0);
         chk("drop_cnt", 32'(drop_cnt), 32'(i + 1));
      end
      vld = 1'b0;
      tick();
      chk("drop_idle", 32'(drop), 0);
      chk("drop_cnt_hold", 32'(drop_cnt), 3);
      for (int i = 0; i < 45; i++) begin
         tick();
         chk("hs_busy_wait", 32'(busy), 1);
      end
      rdy = 1'b1;
      tick();
      chk("hs_busy_fall", 32'(busy), 0);

      // Frame 2: bit-reversed order, sign handling, REV latched only at n=0
      for (int n = 0; n < 16; n++) begin
         brev = (n == 0);
         vld = 1'b1;
         v = (n == 1) ? 14'h3FFF : (n == 2) ? 14'h2000 : 14'(n * 37);
         adc = v;
         tick();
         chk("f2_we", 32'(we), 32'(1 << (n % 4)));
         chk("f2_addr", 32'(addr), 32'(rev_tab[n / 4]));
         chk("f2_data", 32'(data), 32'({v, 8'h00}));
         chk("f2_start", 32'(start), (n == 15) ? 1 : 0);
         if (n == 0) chk("f2_first_bank0", 32'({we, 2'(addr)}), 32'h4);
         if (n == 1) chk("sign_m1", 32'(data), 32'h3FFF00);
         if (n == 2) chk("sign_min", 32'(data), 32'h200000);
      end
      vld = 1'b0; brev = 1'b0;
      chk("f2_busy", 32'(busy), 1);

      // Immediate handshake: RDY already low when WAIT_ACK is entered
      rdy = 1'b0;
      tick();
      tick();
      rdy = 1'b1;
      tick();
      chk("hs2_busy_fall", 32'(busy), 0);

      // Mid-frame reset after 7 samples
      for (int n = 0; n < 7; n++) begin
         vld = 1'b1; brev = 1'b1; adc = 14'(n + 500);
         tick();
      end
      chk("mid_we", 32'(we), 32'h4);
      chk("mid_addr", 32'(addr), 2);
      rst_n = 1'b0; vld = 1'b0; brev = 1'b0;
      tick();
      chk("mrst_we", 32'(we), 0);
      chk("mrst_addr", 32'(addr), 0);
      chk("mrst_data", 32'(data), 0);
      chk("mrst_dropcnt", 32'(drop_cnt), 0);
      chk("mrst_busy", 32'(busy), 0);
      rst_n = 1'b1;

      // Frame 3: full frame after reset, natural order
      for (int n = 0; n < 16; n++) begin
         vld = 1'b1; adc = 14'(n + 200);
         tick();
         chk("f3_we", 32'(we), 32'(1 << (n % 4)));
         chk("f3_addr", 32'(addr), 32'(n / 4));
         chk("f3_start", 32'(start), (n == 15) ? 1 : 0);
      end
      vld = 1'b0;
      tick();
      chk("f3_nowe", 32'(we), 0);
      chk("f3_data_hold", 32'(data), 32'(215 * 256));
      chk("start_total", 32'(start_cnt), 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fht_adc_loader.md
# fht_adc_loader

Front-end loader for `fht_top`. It accepts a stream of signed ADC samples and converts each one to the FHT fixed-point format. It writes one frame of `4*2**A_BIT` samples row by row into the four RAM banks through the `iWE`/`iDATA`/`iADDR_WR` write port, then issues a one-cycle `iSTART`. Its own `oBUSY` stays high until `fht_top` reports completion on `oRDY`; only then is the next frame accepted.

## Interface
Parameters:
- `ADC_WIDTH`, 14: ADC sample width, two's complement.
- `D_BIT`, 22: FHT data width; must be ≥ `ADC_WIDTH`. Fractional bits = `D_BIT-ADC_WIDTH`.
- `A_BIT`, 8: bank address width. Bank depth is `2**A_BIT`; frame length is `4*2**A_BIT`.

Ports:
- `iCLK` in, 1: the single clock.
- `iRESET` in, 1: synchronous, active-low reset.
- `iADC_DATA` in, `ADC_WIDTH`: signed sample.
- `iADC_VALID` in, 1: sample qualifier; one sample per asserted cycle.
- `iBIT_REV` in, 1: address-order select. 0 = row `r` is written at address `r`; 1 = row `r` is written at address `bitrev(r)` over `A_BIT` bits. Sampled at the first sample of each frame.
- `iFHT_RDY` in, 1: `oRDY` of `fht_top`.
- `oWE` out, 4: one-hot bank write enable, to `iWE`.
- `oDATA` out, `D_BIT`: fixed-point sample, to `iDATA`.
- `oADDR_WR` out, `A_BIT`: row address, to `iADDR_WR`.
- `oSTART` out, 1: one-cycle FHT start, to `iSTART`.
- `oBUSY` out, 1: high whenever the block is not in LOAD.
- `oDROP` out, 1: one-cycle pulse for each discarded sample.
- `oDROP_CNT` out, 16: saturating count of dropped samples.

## Operation
- Sample counter `cnt` is `A_BIT+2` bits wide.
  - Bank = `cnt[1:0]`; row = `cnt[A_BIT+1:2]`.
  - Sample `n` goes to bank `n%4`, row `n/4`.
- Conversion: `oDATA = {iADC_DATA, (D_BIT-ADC_WIDTH) zeros}`. There is no rounding and no saturation.
- `iBIT_REV` is latched into `rev_q` when `iADC_VALID` is seen in LOAD with `cnt==0`. The latched value is used for the whole frame.
- LOAD (reset state):
  - Each valid sample produces one write and `cnt` increments.
  - The sample at `cnt == 4*2**A_BIT-1` moves the FSM to START, and `cnt` wraps to 0.
- START:
  - `oSTART=1` for exactly one cycle.
  - Next state is WAIT_ACK.
- WAIT_ACK:
  - Waits for `iFHT_RDY==0`, then moves to WAIT_DONE.
  - If `iFHT_RDY` is already 0 on entry, the transition happens on that cycle.
- WAIT_DONE:
  - Waits for `iFHT_RDY==1`, then moves to LOAD.
- Dropped samples:
  - `iADC_VALID=1` in any state other than LOAD causes no write and `cnt` is unchanged.
  - `oDROP` pulses and `oDROP_CNT` increments, saturating at 16'hFFFF.
- Reset (`iRESET==0` at a clock edge), including mid-frame:
  - State returns to LOAD and `cnt` = 0; the partial frame is abandoned.
  - All outputs go to 0, including `oDROP_CNT` and `rev_q`.
  - RAM contents are untouched.
- Samples at full rate, one per cycle, are accepted continuously in LOAD.

## Timing
- All outputs are registered.
- Write latency:
  - A sample accepted at edge `k` appears on `oWE`/`oDATA`/`oADDR_WR` during cycle `k+1`.
  - `oWE` is 0 in any cycle without a write. `oDATA`/`oADDR_WR` hold their last value when `oWE` is 0.
- Start timing:
  - The last sample is accepted at edge `k`.
  - Its write is visible in cycle `k+1`, and `oSTART` is high in cycle `k+1` as well, so `oBUSY`=1 in `k+1`.
  - `fht_top` registers both on the same edge; the final write is guaranteed to land before processing starts.
- Sampling around start:
  - A sample at edge `k+1` is already dropped.
  - `iFHT_RDY` is first evaluated in the cycle after `oSTART`.
- `oBUSY` falls in the cycle after `iFHT_RDY` is seen high in WAIT_DONE. A sample presented in that same cycle is accepted as `n=0` of the new frame.
- `oDROP` is coincident with its `oDROP_CNT` update, one cycle after the dropped sample.

## Test plan
- Reset then ramp, `A_BIT=2`:
  - Stimulus: samples 0..15 with `iBIT_REV=0`.
  - Required: sample 5 gives `oWE=4'b0010`, `oADDR_WR=1`, `oDATA=5<<8` (`D_BIT=22`, `ADC_WIDTH=14`).
  - Required: exactly one `oSTART`, in the same cycle as the write of sample 15.
- Bit-reverse mode, `A_BIT=2`: with `iBIT_REV=1`, samples 4..7 (row 1) are written at address 2; rows 2 and 3 are written at addresses 1 and 3.
- Sign handling: sample `-1` (14'h3FFF) gives `oDATA=22'h3FFF00`; sample `-8192` gives `22'h200000`.
- Drop path:
  - Stimulus: 3 valid samples while in WAIT_DONE.
  - Required: 3 `oDROP` pulses, `oDROP_CNT=3`, no `oWE`.
  - Required: `iFHT_RDY` rising returns the block to LOAD, and the next sample goes to bank 0, row 0.
- Reset mid-frame:
  - Stimulus: `iRESET=0` after 7 samples, then a full frame.
  - Required: no `oSTART` until 16 new samples have been loaded; the first post-reset write is at bank 0, address 0.
- Handshake with `fht_top` model: `iFHT_RDY` drops 3 cycles after `oSTART` and rises 50 cycles later; `oBUSY` stays high throughout and falls one cycle after the rise.
